// File: rtl/ppfifo_wr_arbiter.sv
// Per-buffer round-robin arbiter sharing one ping-pong FIFO write port between two requesters.
// Optional strobe-count guard against over-size writes: define PPFIFO_WR_ARB_OVERFLOW_GUARD_EN.
module ppfifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_wr_rdy,
  output logic [1:0]            o_wr_act,
  input  logic [SIZE_WIDTH-1:0] i_wr_size,
  output logic                  o_wr_stb,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_r0_req,
  input  logic                  i_r1_req,
  output logic                  o_r0_rdy,
  output logic                  o_r1_rdy,
  input  logic                  i_r0_act,
  input  logic                  i_r1_act,
  output logic [SIZE_WIDTH-1:0] o_r0_size,
  output logic [SIZE_WIDTH-1:0] o_r1_size,
  input  logic                  i_r0_stb,
  input  logic                  i_r1_stb,
  input  logic [DATA_WIDTH-1:0] i_r0_data,
  input  logic [DATA_WIDTH-1:0] i_r1_data,
  output logic                  o_busy,
  output logic [31:0]           o_buf_count,
  output logic                  o_overflow
);

  typedef enum logic [1:0] {IDLE, OFFER, ACTIVE, RELEASE} state_e;

  state_e                state_q, state_d;
  logic                  winner_q, winner_d;
  logic                  prio_q;
  logic [1:0]            act_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic                  stb_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           count_q;

  logic                  acquire;
  logic                  winReq, othReq, winAct, winStb;
  logic [DATA_WIDTH-1:0] winData;
  logic                  fwdStb;

  assign winReq  = winner_q ? i_r1_req  : i_r0_req;
  assign othReq  = winner_q ? i_r0_req  : i_r1_req;
  assign winAct  = winner_q ? i_r1_act  : i_r0_act;
  assign winStb  = winner_q ? i_r1_stb  : i_r0_stb;
  assign winData = winner_q ? i_r1_data : i_r0_data;

  assign acquire = (state_q == IDLE) && (i_wr_rdy != 2'b00) && (act_q == 2'b00)
                   && (i_r0_req || i_r1_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acquire) state_d = OFFER;
      OFFER:   if (winAct)  state_d = ACTIVE;
      ACTIVE:  if (!winAct) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A requester that gives up its offer hands the held buffer to a waiting peer.
  always_comb begin
    winner_d = winner_q;
    if (acquire)
      winner_d = (i_r0_req && i_r1_req) ? prio_q : i_r1_req;
    else if ((state_q == OFFER) && !winAct && !winReq && othReq)
      winner_d = ~winner_q;
  end

  always_comb begin
    o_busy    = (state_q != IDLE);
    o_r0_rdy  = (state_q == OFFER) && !winner_q;
    o_r1_rdy  = (state_q == OFFER) &&  winner_q;
    o_r0_size = (o_busy && !winner_q) ? size_q : '0;
    o_r1_size = (o_busy &&  winner_q) ? size_q : '0;
  end

`ifdef PPFIFO_WR_ARB_OVERFLOW_GUARD_EN
  logic [SIZE_WIDTH-1:0] fill_q;
  logic                  ovf_q;
  logic                  overSize;

  assign overSize = (fill_q == size_q);
  assign fwdStb   = (state_q == ACTIVE) && winStb && !overSize;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (acquire)     fill_q <= '0;
      else if (fwdStb) fill_q <= fill_q + SIZE_WIDTH'(1);
      if ((state_q == ACTIVE) && winStb && overSize) ovf_q <= 1'b1;
    end
  end

  assign o_overflow = ovf_q;
`else
  assign fwdStb     = (state_q == ACTIVE) && winStb;
  assign o_overflow = 1'b0;
`endif

  // Downstream act stays up through RELEASE so the final registered strobe lands inside the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q <= 1'b0;
      prio_q   <= 1'b0;
      act_q    <= 2'b00;
      size_q   <= '0;
      stb_q    <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      winner_q <= winner_d;
      stb_q    <= fwdStb;
      if (fwdStb) data_q <= winData;
      if (acquire) begin
        act_q  <= i_wr_rdy[0] ? 2'b01 : 2'b10;
        size_q <= i_wr_size;
      end
      if (state_q == RELEASE) begin
        act_q   <= 2'b00;
        count_q <= count_q + 32'd1;
        prio_q  <= ~winner_q;
      end
    end
  end

  assign o_wr_act    = act_q;
  assign o_wr_stb    = stb_q;
  assign o_wr_data   = data_q;
  assign o_buf_count = count_q;

endmodule

// File: tb/tb_ppfifo_wr_arbiter.sv
// Bench for ppfifo_wr_arbiter: directed vector table, hand-written corner sequences and
// randomized buffers checked against a transaction-level round-robin / write-queue model.
module tb_ppfifo_wr_arbiter;
  localparam int DW = 32;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wrRdy, wrAct;
  logic [SW-1:0] wrSize;
  logic          wrStb;
  logic [DW-1:0] wrData;
  logic          r0Req, r1Req, r0Rdy, r1Rdy, r0Act, r1Act, r0Stb, r1Stb;
  logic [SW-1:0] r0Size, r1Size;
  logic [DW-1:0] r0Data, r1Data;
  logic          busy, overflow;
  logic [31:0]   bufCount;

  ppfifo_wr_arbiter #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .i_wr_rdy(wrRdy), .o_wr_act(wrAct), .i_wr_size(wrSize),
    .o_wr_stb(wrStb), .o_wr_data(wrData),
    .i_r0_req(r0Req), .i_r1_req(r1Req), .o_r0_rdy(r0Rdy), .o_r1_rdy(r1Rdy),
    .i_r0_act(r0Act), .i_r1_act(r1Act), .o_r0_size(r0Size), .o_r1_size(r1Size),
    .i_r0_stb(r0Stb), .i_r1_stb(r1Stb), .i_r0_data(r0Data), .i_r1_data(r1Data),
    .o_busy(busy), .o_buf_count(bufCount), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    logic [1:0]    req, act, stb, rdy;
    logic [DW-1:0] d0, d1;
    logic [SW-1:0] size;
    logic [1:0]    eAct, eRdy;
    logic [SW-1:0] eSize0, eSize1;
    logic          eStb;
    logic [DW-1:0] eData;
    logic          eBusy;
    logic [31:0]   eCount;
  } vec_t;

  vec_t vecs[22];

  // Reference model state: round-robin pointer, released-buffer count, sticky overflow, expected writes.
  int            mPrio = 0;
  int            mCount = 0;
  bit            mOvf = 1'b0;
  logic [DW-1:0] expQ[$];
  logic [1:0]    mAct = 2'b00;
  bit            monOn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    r0Req = 1'b0; r1Req = 1'b0; r0Act = 1'b0; r1Act = 1'b0;
    r0Stb = 1'b0; r1Stb = 1'b0; r0Data = '0; r1Data = '0;
    wrRdy = 2'b00; wrSize = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    r0Req = v.req[0]; r1Req = v.req[1];
    r0Act = v.act[0]; r1Act = v.act[1];
    r0Stb = v.stb[0]; r1Stb = v.stb[1];
    r0Data = v.d0; r1Data = v.d1;
    wrRdy = v.rdy; wrSize = v.size;
  endtask

  task automatic checkOffer(input string tag, input int w, input logic [1:0] ch, input logic [SW-1:0] sz);
    checkOutput({tag, " r0_rdy"}, 64'(r0Rdy), 64'(w == 0));
    checkOutput({tag, " r1_rdy"}, 64'(r1Rdy), 64'(w == 1));
    checkOutput({tag, " wr_act"}, 64'(wrAct), 64'(ch));
    checkOutput({tag, " size"}, 64'((w == 0) ? r0Size : r1Size), 64'(sz));
    checkOutput({tag, " loser size"}, 64'((w == 0) ? r1Size : r0Size), 64'd0);
  endtask

  // Every forwarded strobe must be the oldest outstanding winner write, inside the held buffer.
  always @(negedge clk) begin
    if (monOn && wrStb) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL rnd stray stb: got data %0h, want no strobe", wrData);
      end else begin
        checkOutput("rnd data", 64'(wrData), 64'(expQ.pop_front()));
        checkOutput("rnd act during stb", 64'(wrAct), 64'(mAct));
      end
    end
  end

  task automatic doBuffer(input bit q0, input bit q1, input bit dropW, input logic [1:0] rdy,
                          input logic [SW-1:0] sz, input int nCyc, input bit fallWithStb);
    int            w;
    int            fill;
    logic [1:0]    ch;
    bit            ws;
    logic [DW-1:0] wd;
    fill = 0;
    w    = (q0 && q1) ? mPrio : (q1 ? 1 : 0);
    ch   = rdy[0] ? 2'b01 : 2'b10;
    mAct = ch;
    r0Req = q0; r1Req = q1; wrRdy = rdy; wrSize = sz;
    r0Stb = 1'($urandom_range(0, 1)); r1Stb = 1'($urandom_range(0, 1));
    r0Data = $urandom; r1Data = $urandom;
    @(negedge clk);
    wrRdy = 2'b00; wrSize = SW'($urandom);
    checkOffer("rnd offer", w, ch, sz);
    if (dropW && q0 && q1) begin
      if (w == 0) r0Req = 1'b0; else r1Req = 1'b0;
      w = 1 - w;
      @(negedge clk);
      checkOffer("rnd switch", w, ch, sz);
    end
    if (w == 0) r0Act = 1'b1; else r1Act = 1'b1;
    @(negedge clk);
    checkOutput("rnd active busy", 64'(busy), 64'd1);
    checkOutput("rnd active rdy", 64'({r1Rdy, r0Rdy}), 64'd0);
    for (int k = 0; k < nCyc; k++) begin
      r0Stb = 1'($urandom_range(0, 1)); r1Stb = 1'($urandom_range(0, 1));
      r0Data = $urandom; r1Data = $urandom;
      if (k == nCyc - 1 && fallWithStb) begin
        if (w == 0) begin r0Stb = 1'b1; r0Act = 1'b0; end
        else        begin r1Stb = 1'b1; r1Act = 1'b0; end
      end
      ws = (w == 0) ? r0Stb : r1Stb;
      wd = (w == 0) ? r0Data : r1Data;
      if (ws) begin
`ifdef PPFIFO_WR_ARB_OVERFLOW_GUARD_EN
        if (fill == int'(sz)) mOvf = 1'b1;
        else begin expQ.push_back(wd); fill++; end
`else
        expQ.push_back(wd);
`endif
      end
      @(negedge clk);
    end
    if (!(fallWithStb && nCyc > 0)) begin
      r0Act = 1'b0; r1Act = 1'b0; r0Stb = 1'b0; r1Stb = 1'b0;
      @(negedge clk);
    end
    clearInputs();
    @(negedge clk);
    mCount++;
    mPrio = 1 - w;
    checkOutput("rnd end act", 64'(wrAct), 64'd0);
    checkOutput("rnd end busy", 64'(busy), 64'd0);
    checkOutput("rnd end count", 64'(bufCount), 64'(mCount));
    checkOutput("rnd end overflow", 64'(overflow), 64'(mOvf));
    checkOutput("rnd end pending writes", 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  initial begin
    int pulses;
    // Fields: req, act, stb, rdy, d0, d1, size | eAct, eRdy{r1,r0}, eSize0, eSize1, eStb, eData, eBusy, eCount
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 24'd4, 2'b01, 2'b01, 24'd4, 24'd0, 1'b0, 32'h0, 1'b1, 32'd0};
    vecs[1]  = '{2'b01, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b01, 2'b00, 24'd4, 24'd0, 1'b0, 32'h0, 1'b1, 32'd0};
    vecs[2]  = '{2'b01, 2'b01, 2'b01, 2'b00, 32'h0, 32'h0, 24'd0, 2'b01, 2'b00, 24'd4, 24'd0, 1'b1, 32'h0, 1'b1, 32'd0};
    vecs[3]  = '{2'b01, 2'b01, 2'b01, 2'b00, 32'h1, 32'h0, 24'd0, 2'b01, 2'b00, 24'd4, 24'd0, 1'b1, 32'h1, 1'b1, 32'd0};
    vecs[4]  = '{2'b01, 2'b01, 2'b01, 2'b00, 32'h2, 32'h0, 24'd0, 2'b01, 2'b00, 24'd4, 24'd0, 1'b1, 32'h2, 1'b1, 32'd0};
    vecs[5]  = '{2'b00, 2'b00, 2'b01, 2'b00, 32'h3, 32'h0, 24'd0, 2'b01, 2'b00, 24'd4, 24'd0, 1'b1, 32'h3, 1'b1, 32'd0};
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b00, 2'b00, 24'd0, 24'd0, 1'b0, 32'h0, 1'b0, 32'd1};
    vecs[7]  = '{2'b01, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 24'd9, 2'b01, 2'b01, 24'd9, 24'd0, 1'b0, 32'h0, 1'b1, 32'd1};
    vecs[8]  = '{2'b01, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b01, 2'b00, 24'd9, 24'd0, 1'b0, 32'h0, 1'b1, 32'd1};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b01, 2'b00, 24'd9, 24'd0, 1'b0, 32'h0, 1'b1, 32'd1};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b00, 2'b00, 24'd0, 24'd0, 1'b0, 32'h0, 1'b0, 32'd2};
    vecs[11] = '{2'b01, 2'b00, 2'b00, 2'b10, 32'h0, 32'h0, 24'd9, 2'b10, 2'b01, 24'd9, 24'd0, 1'b0, 32'h0, 1'b1, 32'd2};
    vecs[12] = '{2'b01, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b10, 2'b00, 24'd9, 24'd0, 1'b0, 32'h0, 1'b1, 32'd2};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b10, 2'b00, 24'd9, 24'd0, 1'b0, 32'h0, 1'b1, 32'd2};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b00, 2'b00, 24'd0, 24'd0, 1'b0, 32'h0, 1'b0, 32'd3};
    vecs[15] = '{2'b01, 2'b00, 2'b01, 2'b01, 32'hEE, 32'h0, 24'd7, 2'b01, 2'b01, 24'd7, 24'd0, 1'b0, 32'h0, 1'b1, 32'd3};
    vecs[16] = '{2'b10, 2'b00, 2'b11, 2'b00, 32'hCC, 32'hDD, 24'd3, 2'b01, 2'b10, 24'd0, 24'd7, 1'b0, 32'h0, 1'b1, 32'd3};
    vecs[17] = '{2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b01, 2'b00, 24'd0, 24'd7, 1'b0, 32'h0, 1'b1, 32'd3};
    vecs[18] = '{2'b10, 2'b10, 2'b11, 2'b00, 32'hAA, 32'h55, 24'd0, 2'b01, 2'b00, 24'd0, 24'd7, 1'b1, 32'h55, 1'b1, 32'd3};
    vecs[19] = '{2'b10, 2'b10, 2'b01, 2'b00, 32'hBB, 32'h0, 24'd0, 2'b01, 2'b00, 24'd0, 24'd7, 1'b0, 32'h0, 1'b1, 32'd3};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b01, 2'b00, 24'd0, 24'd7, 1'b0, 32'h0, 1'b1, 32'd3};
    vecs[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 24'd0, 2'b00, 2'b00, 24'd0, 24'd0, 1'b0, 32'h0, 1'b0, 32'd4};

    clearInputs();
    rst = 1'b1;
    #1;
    checkOutput("reset wr_act", 64'(wrAct), 64'd0);
    checkOutput("reset wr_stb", 64'(wrStb), 64'd0);
    checkOutput("reset wr_data", 64'(wrData), 64'd0);
    checkOutput("reset rdy", 64'({r1Rdy, r0Rdy}), 64'd0);
    checkOutput("reset sizes", 64'({r1Size, r0Size}), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset count", 64'(bufCount), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d wr_act", i), 64'(wrAct), 64'(vecs[i].eAct));
      checkOutput($sformatf("vec%0d rdy", i), 64'({r1Rdy, r0Rdy}), 64'(vecs[i].eRdy));
      checkOutput($sformatf("vec%0d r0_size", i), 64'(r0Size), 64'(vecs[i].eSize0));
      checkOutput($sformatf("vec%0d r1_size", i), 64'(r1Size), 64'(vecs[i].eSize1));
      checkOutput($sformatf("vec%0d wr_stb", i), 64'(wrStb), 64'(vecs[i].eStb));
      if (vecs[i].eStb)
        checkOutput($sformatf("vec%0d wr_data", i), 64'(wrData), 64'(vecs[i].eData));
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d count", i), 64'(bufCount), 64'(vecs[i].eCount));
    end
    clearInputs();

    // Size 2 buffer receiving 3 winner strobes.
    pulses = 0;
    r0Req = 1'b1; wrRdy = 2'b01; wrSize = 24'd2;
    @(negedge clk);
    wrRdy = 2'b00; r0Act = 1'b1;
    @(negedge clk);
    r0Stb = 1'b1;
    for (int j = 0; j < 3; j++) begin
      r0Data = 32'h100 + 32'(j);
      @(negedge clk);
      if (wrStb) pulses++;
    end
    r0Stb = 1'b0; r0Act = 1'b0; r0Req = 1'b0;
    @(negedge clk);
    if (wrStb) pulses++;
    @(negedge clk);
    checkOutput("guard count", 64'(bufCount), 64'd5);
`ifdef PPFIFO_WR_ARB_OVERFLOW_GUARD_EN
    checkOutput("guard forwarded", 64'(pulses), 64'd2);
    checkOutput("guard overflow", 64'(overflow), 64'd1);
    repeat (2) @(negedge clk);
    checkOutput("guard overflow sticky", 64'(overflow), 64'd1);
`else
    checkOutput("guard forwarded", 64'(pulses), 64'd3);
    checkOutput("guard overflow", 64'(overflow), 64'd0);
`endif
    rst = 1'b1;
    #1;
    checkOutput("guard overflow after rst", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-size buffer: offered, then released with no writes.
    r0Req = 1'b1; wrRdy = 2'b10; wrSize = 24'd0;
    @(negedge clk);
    wrRdy = 2'b00;
    checkOffer("zero offer", 0, 2'b10, 24'd0);
    r0Act = 1'b1;
    @(negedge clk);
    r0Act = 1'b0; r0Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("zero count", 64'(bufCount), 64'd1);
    checkOutput("zero act", 64'(wrAct), 64'd0);

    // Reset while a strobe is being forwarded.
    r0Req = 1'b1; wrRdy = 2'b01; wrSize = 24'd8;
    @(negedge clk);
    wrRdy = 2'b00; r0Act = 1'b1;
    @(negedge clk);
    r0Stb = 1'b1; r0Data = 32'h42;
    @(posedge clk);
    #2;
    checkOutput("rstmid pre stb", 64'(wrStb), 64'd1);
    checkOutput("rstmid pre busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid wr_act", 64'(wrAct), 64'd0);
    checkOutput("rstmid wr_stb", 64'(wrStb), 64'd0);
    checkOutput("rstmid r0_rdy", 64'(r0Rdy), 64'd0);
    checkOutput("rstmid busy", 64'(busy), 64'd0);
    checkOutput("rstmid count", 64'(bufCount), 64'd0);
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid idle busy", 64'(busy), 64'd0);
    checkOutput("rstmid idle act", 64'(wrAct), 64'd0);

    mPrio = 0; mCount = 0; mOvf = 1'b0; expQ.delete();
    monOn = 1'b1;
    for (int i = 0; i < 4; i++)
      doBuffer(1'b1, 1'b1, 1'b0, 2'($urandom_range(1, 3)), 24'd6, 4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      doBuffer(pat[0], pat[1], 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
               SW'($urandom_range(0, 5)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    monOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #1000000;
    nMismatch++;
    $display("[TB] FAIL watchdog: got no completion, want completion before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/ppfifo_wr_arbiter.md
Name: ppfifo_wr_arbiter

Overview:
Shares one ping-pong FIFO write interface between two requesters (r0, r1), e.g. two data-generator style sources. Arbitration is per buffer: a winner owns a whole downstream buffer from acquire to release. Round-robin priority between requesters. Each requester sees a single-buffer write handshake (rdy/act/size/stb/data); the arbiter owns the downstream two-channel act selection.

Parameters:
DATA_WIDTH  32  width of write data, downstream and both requesters
SIZE_WIDTH  24  width of buffer size fields

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_wr_rdy  in  2  downstream ping-pong ready, one bit per buffer
o_wr_act  out  2  downstream buffer activate, at most one bit set
i_wr_size  in  SIZE_WIDTH  downstream buffer size in words
o_wr_stb  out  1  downstream write strobe
o_wr_data  out  DATA_WIDTH  downstream write data
i_r0_req, i_r1_req  in  1  requester wants a buffer
o_r0_rdy, o_r1_rdy  out  1  buffer offered to requester
i_r0_act, i_r1_act  in  1  requester holds offered buffer
o_r0_size, o_r1_size  out  SIZE_WIDTH  size of offered buffer, 0 when not winner
i_r0_stb, i_r1_stb  in  1  requester write strobe
i_r0_data, i_r1_data  in  DATA_WIDTH  requester write data
o_busy  out  1  state != IDLE
o_buf_count  out  32  buffers released downstream, wraps at 2^32
o_overflow  out  1  sticky over-size strobe flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; priority pointer = r0; latched size = 0; winner = r0.
- States: IDLE, OFFER, ACTIVE, RELEASE.
- IDLE: wait for (i_wr_rdy != 0) and (o_wr_act == 0) and any req.
  - o_wr_act <= 2'b01 if i_wr_rdy[0], else 2'b10. Channel 0 wins if both ready.
  - Latch i_wr_size.
  - Winner: the only requester, or the priority pointer when both request.
  - Next state OFFER.
- OFFER: o_rW_rdy = 1 and o_rW_size = latched size, for the winner W only.
  - i_rW_act=1 -> ACTIVE; o_rW_rdy drops the next cycle.
  - i_rW_req drops before act and the other requester has req=1 -> winner switches to the other requester. Downstream buffer is retained; state stays OFFER.
  - i_rW_req drops and the other requester is idle -> stay OFFER, buffer held. An empty buffer is never released.
- ACTIVE: o_wr_stb <= i_rW_stb and o_wr_data <= i_rW_data, registered (1-cycle latency).
  - Non-winner strobes are ignored in every state.
  - Stb outside ACTIVE is ignored.
  - i_rW_act falls -> RELEASE. A strobe present in the act-fall cycle is still forwarded.
- RELEASE (one cycle): o_wr_act <= 0; o_buf_count += 1; priority pointer <= other requester; -> IDLE.
  - Downstream act stays high through the cycle in which the last registered strobe appears.
- o_wr_stb is 0 every cycle not driven by a forwarded strobe.
- Reset mid-operation: all outputs clear immediately. Requesters must treat rdy falling as buffer loss.
- i_wr_size with value 0: still acquired and offered; the requester may release with no writes.

Optional Feature:
Macro PPFIFO_WR_ARB_OVERFLOW_GUARD_EN.
- Defined:
  - A SIZE_WIDTH counter clears on each acquire.
  - Each forwarded strobe increments it.
  - Winner strobes arriving when count == latched size are dropped (not forwarded) and set o_overflow. o_overflow stays set until reset.
- Undefined: no counter; all winner strobes are forwarded; o_overflow tied 0.

Test Plan:
- Only r0 requests, i_wr_rdy=01, size=4, 4 strobes with data 0..3 -> o_wr_act=01, 4 o_wr_stb pulses carrying 0..3 one cycle after input, act clears after r0 act falls, o_buf_count=1.
- r0 and r1 request together over 4 buffers -> grants alternate r0,r1,r0,r1; non-winner strobes never reach o_wr_stb.
- i_wr_rdy=11 in IDLE -> o_wr_act=01; next buffer with i_wr_rdy=10 -> o_wr_act=10.
- r0 drops req in OFFER while r1 requests -> o_r1_rdy=1 with the same latched size; o_wr_act unchanged, no extra acquire.
- Guard enabled, size=2, r0 sends 3 strobes -> exactly 2 forwarded, o_overflow=1 until rst. Guard disabled -> 3 forwarded, o_overflow=0.
- Assert rst during ACTIVE -> o_wr_act, o_wr_stb, o_r0_rdy, o_busy all 0 within the same cycle; state IDLE after release.
